shared_mult_ctrl: RTL and testbench

SHARED_MULT_CTRL -- requirements
Module: shared_mult_ctrl

---
 rtl/shared_mult_ctrl.sv | 131 +++++++++++++
 tb/tb_shared_mult_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mult_ctrl.sv
// rtl/shared_mult_ctrl.sv - round-robin time-shared shift-add multiplier for two requesters.
// Optional SHARED_MULT_SAT_EN clamps result_o to 2^WIDTH-1 (LED-display mode).
module shared_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_i,
  input  logic [WIDTH-1:0]   opa0_i,
  input  logic [WIDTH-1:0]   opb0_i,
  input  logic [WIDTH-1:0]   opa1_i,
  input  logic [WIDTH-1:0]   opb1_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               win_q, win_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic               winner;

  function automatic logic [2*WIDTH-1:0] shape(input logic [2*WIDTH-1:0] p);
`ifdef SHARED_MULT_SAT_EN
    if (p[2*WIDTH-1:WIDTH] != '0) begin
      return {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
    end
    return p;
`else
    return p;
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    result_d = result_q;
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;

    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    // with both requesting, the one not served last wins
    winner  = req_i[1] & (~req_i[0] | ~last_q);

    case (state_q)
      CALC: begin
        busy_d   = 1'b1;
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          done_d   = win_q ? 2'b10 : 2'b01;
          result_d = shape(acc_sum);
        end
      end
      default: begin
        // IDLE and DONE both arbitrate, so back-to-back jobs lose no cycle
        state_d = IDLE;
        busy_d  = 1'b0;
        if (req_i != 2'b00) begin
          state_d  = CALC;
          busy_d   = 1'b1;
          win_d    = winner;
          last_d   = winner;
          gnt_d    = winner ? 2'b10 : 2'b01;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, (winner ? opa1_i : opa0_i)};
          mplier_d = winner ? opb1_i : opb0_i;
          cnt_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= '0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_shared_mult_ctrl.sv
// tb/tb_shared_mult_ctrl.sv - scoreboard bench for shared_mult_ctrl with a transaction-level model.
module tb_shared_mult_ctrl;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_i = 2'b00;
  logic [W-1:0]   opa0_i = '0, opb0_i = '0, opa1_i = '0, opb1_i = '0;
  logic [1:0]     gnt_o, done_o;
  logic [2*W-1:0] result_o;
  logic           busy_o;

  shared_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i),
    .opa0_i(opa0_i), .opb0_i(opb0_i), .opa1_i(opa1_i), .opb1_i(opb1_i),
    .gnt_o(gnt_o), .done_o(done_o), .result_o(result_o), .busy_o(busy_o)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int             who;
    logic [2*W-1:0] res;
    int             due;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int             n = 0;
  int             free_edge = 0;
  int             last_srv = 1;
  int             win;
  logic [1:0]     exp_gnt = 2'b00;
  logic [2*W-1:0] exp_res = '0;
  int             dn_who[$];
  int             dn_t[$];
  logic [2*W-1:0] dn_res[$];
  logic [1:0]     hold_mask = 2'b00;
  bit             rnd_mode = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_result(input longint a, input longint b);
    longint p;
    p = a * b;
`ifdef SHARED_MULT_SAT_EN
    if (p > (longint'(1) << W) - 1) p = (longint'(1) << W) - 1;
`endif
    return p[2*W-1:0];
  endfunction

  // Reference: a job granted at edge g completes visibly after edge g+W; next grant no earlier than g+W+1.
  always @(posedge clk) begin
    n++;
    exp_gnt = 2'b00;
    if (!rst_n) begin
      free_edge = 0;
      last_srv  = 1;
      sb.delete();
      exp_res   = '0;
    end else if (n >= free_edge && req_i != 2'b00) begin
      if (req_i == 2'b01)      win = 0;
      else if (req_i == 2'b10) win = 1;
      else                     win = 1 - last_srv;
      last_srv     = win;
      exp_gnt[win] = 1'b1;
      sb.push_back('{win, (win == 1) ? ref_result(opa1_i, opb1_i) : ref_result(opa0_i, opb0_i), n + W});
      free_edge = n + W + 1;
    end
  end

  always @(negedge clk) begin
    chk("gnt_o", gnt_o, exp_gnt);
    chk("busy_o", busy_o, (n < free_edge));
    if (done_o != 2'b00) begin
      dn_who.push_back(int'(done_o[1]));
      dn_t.push_back(n);
      dn_res.push_back(result_o);
      if (sb.size() == 0) begin
        chk("done_unexpected", done_o, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_who", done_o, longint'(1) << mon_e.who);
        chk("done_time", n, mon_e.due);
        exp_res = mon_e.res;
      end
    end else if (sb.size() != 0 && sb[0].due <= n) begin
      mon_e = sb.pop_front();
      chk("done_missing", done_o, longint'(1) << mon_e.who);
      exp_res = mon_e.res;
    end
    chk("result_o", result_o, exp_res);
  end

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
    if (rnd_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (req_i[i]) begin
          if (gnt_o[i]) req_i[i] = 1'b0;
          else if ($urandom_range(0, 15) == 0) req_i[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_i[i] = 1'b1;
        end
      end
      opa0_i = rnd_op(); opb0_i = rnd_op();
      opa1_i = rnd_op(); opb1_i = rnd_op();
    end else begin
      req_i = req_i & ~(gnt_o & ~hold_mask);
    end
  endtask

  task automatic wait_gnt(input string name, output int t);
    int k;
    k = 0;
    step();
    while (gnt_o == 2'b00 && k < 50) begin
      step();
      k++;
    end
    t = n;
    if (k >= 50) chk({name, "_gnt_timeout"}, k, 0);
  endtask

  task automatic wait_dones(input int cnt, input string name);
    int start;
    int k;
    start = dn_who.size();
    k = 0;
    while (dn_who.size() < start + cnt && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) chk({name, "_done_timeout"}, dn_who.size() - start, cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req_i = 2'b00;
    step();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_busy", busy_o, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int t_req, t_gnt, nd;
    do_reset();

    // single request, fixed latency, operands changed after grant
    step();
    opa0_i = 8'd5; opb0_i = 8'd3; req_i = 2'b01; t_req = n;
    wait_gnt("t1", t_gnt);
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_gnt_latency", t_gnt - t_req, 1);
    opa0_i = 8'hAA; opb0_i = 8'h55;
    wait_dones(1, "t1");
    chk("t1_result", result_o, 15);
    chk("t1_done_latency", dn_t[$] - t_gnt, W);

    // contention straight from reset: requester 0 first
    do_reset();
    opa0_i = 8'd2; opb0_i = 8'd2; opa1_i = 8'd7; opb1_i = 8'd6; req_i = 2'b11;
    wait_gnt("t2", t_gnt);
    chk("t2_first_gnt", gnt_o, 2'b01);
    wait_dones(2, "t2");
    chk("t2_who0", dn_who[dn_who.size()-2], 0);
    chk("t2_res0", dn_res[dn_res.size()-2], 4);
    chk("t2_who1", dn_who[$], 1);
    chk("t2_res1", dn_res[$], 42);
    chk("t2_gap", dn_t[$] - dn_t[dn_t.size()-2], W + 1);

    // maximum operands
    step();
    opa0_i = 8'd255; opb0_i = 8'd255; req_i = 2'b01;
    wait_gnt("t3", t_gnt);
    wait_dones(1, "t3");
`ifdef SHARED_MULT_SAT_EN
    chk("t3_result", result_o, 255);
`else
    chk("t3_result", result_o, 65025);
`endif

    // reset in the fourth CALC cycle aborts the job
    step();
    opa0_i = 8'd13; opb0_i = 8'd11; req_i = 2'b01;
    wait_gnt("t4", t_gnt);
    step(); step(); step();
    nd = dn_who.size();
    rst_n = 1'b0;
    step();
    chk("t4_rst_gnt", gnt_o, 0);
    chk("t4_rst_done", done_o, 0);
    chk("t4_rst_result", result_o, 0);
    chk("t4_rst_busy", busy_o, 0);
    rst_n = 1'b1;
    repeat (W + 3) step();
    chk("t4_no_done", dn_who.size(), nd);
    opa0_i = 8'd9; opb0_i = 8'd9; req_i = 2'b01;
    wait_gnt("t4b", t_gnt);
    wait_dones(1, "t4b");
    chk("t4_fresh_result", result_o, 81);

    // requester 1 holds its request; requester 0 joins mid-job
    hold_mask = 2'b10;
    step();
    opa1_i = 8'd3; opb1_i = 8'd4; req_i = 2'b10;
    wait_gnt("t5", t_gnt);
    chk("t5_gnt1", gnt_o, 2'b10);
    step(); step(); step();
    req_i[0] = 1'b1; opa0_i = 8'd6; opb0_i = 8'd7;
    opa1_i = 8'hFF; opb1_i = 8'hFF;
    wait_dones(2, "t5");
    chk("t5_who_a", dn_who[dn_who.size()-2], 1);
    chk("t5_res_a", dn_res[dn_res.size()-2], 12);
    chk("t5_who_b", dn_who[$], 0);
    chk("t5_res_b", dn_res[$], 42);
    hold_mask = 2'b00;
    step();
    chk("t5_rearb_gnt", gnt_o, 2'b10);
    wait_dones(1, "t5c");

    // random traffic against the reference model
    rnd_mode = 1'b1;
    repeat (500) step();
    rnd_mode = 1'b0;
    req_i = 2'b00;
    repeat (2 * W + 4) step();
    chk("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
